// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: restartable, abortable sequencer for an external LFSR.
// On an accepted start it loads a seed into the LFSR, issues a programmable
// number of shift strobes, captures the final LFSR state and offers it on a
// valid/ready output.
// Optional feature macro: LFSR_ZERO_SEED_FIX_EN. When defined, a zero seed is
// replaced by DEFAULT_SEED and seed_fixed flags the substitution.
module lfsr_seq_ctrl #(
  parameter int                WIDTH        = 4,
  parameter int                CNT_W        = 4,
  parameter int                SHIFT_CNT    = 8,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(4'b1001)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] cfg_shifts,
  input  logic [WIDTH-1:0] lfsr_state,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_shift,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] shifts_done,
  output logic             seed_fixed
);

`ifdef LFSR_ZERO_SEED_FIX_EN
  localparam bit ZERO_FIX = 1'b1;
`else
  // Zero seeds pass straight through; the LFSR then stays locked at zero.
  localparam bit ZERO_FIX = 1'b0;
`endif

  localparam logic [CNT_W-1:0] SHIFT_CNT_C = CNT_W'(SHIFT_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] seed_reg, seed_next;
  logic [CNT_W-1:0] target_reg, target_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             fixed_reg, fixed_next;
  logic             load_reg, load_next;
  logic             shift_reg, shift_next;
  logic             busy_reg, busy_next;
  logic             valid_reg, valid_next;

  // Next-state and next-output decode; strobes are derived from the next
  // state so that every output is a flop aligned with the state it reflects.
  always_comb begin
    state_next  = state_reg;
    seed_next   = seed_reg;
    target_next = target_reg;
    count_next  = count_reg;
    data_next   = data_reg;
    fixed_next  = fixed_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          seed_next   = (ZERO_FIX && (seed == '0)) ? DEFAULT_SEED : seed;
          fixed_next  = ZERO_FIX && (seed == '0);
          target_next = (cfg_shifts == '0) ? SHIFT_CNT_C : cfg_shifts;
          count_next  = '0;
          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The first RUN cycle already shows one shift issued.
        count_next = count_reg + CNT_ONE;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        // count_reg equals the number of shift strobes including this cycle.
        if (count_reg == target_reg) begin
          state_next = ST_CAPTURE;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        // lfsr_state already includes the last shift at this point.
        data_next  = lfsr_state;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort wins over everything outside IDLE and freezes count and data.
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      count_next = count_reg;
      data_next  = data_reg;
    end

    load_next  = (state_next == ST_LOAD);
    shift_next = (state_next == ST_RUN);
    valid_next = (state_next == ST_DONE);
    busy_next  = (state_next != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      seed_reg   <= '0;
      target_reg <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
      fixed_reg  <= 1'b0;
      load_reg   <= 1'b0;
      shift_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      seed_reg   <= seed_next;
      target_reg <= target_next;
      count_reg  <= count_next;
      data_reg   <= data_next;
      fixed_reg  <= fixed_next;
      load_reg   <= load_next;
      shift_reg  <= shift_next;
      busy_reg   <= busy_next;
      valid_reg  <= valid_next;
    end
  end

  assign lfsr_load   = load_reg;
  assign lfsr_seed   = seed_reg;
  assign lfsr_shift  = shift_reg;
  assign busy        = busy_reg;
  assign out_valid   = valid_reg;
  assign out_data    = data_reg;
  assign shifts_done = count_reg;
  assign seed_fixed  = fixed_reg;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl with a behavioural LFSR datapath and
// a reference result computed by iterating the LFSR step function.
module tb_lfsr_seq_ctrl;

`ifdef LFSR_ZERO_SEED_FIX_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] seed;
  logic [3:0] cfg_shifts;
  logic [3:0] lfsr_state;
  logic       lfsr_load;
  logic [3:0] lfsr_seed;
  logic       lfsr_shift;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] shifts_done;
  logic       seed_fixed;

  int checks = 0;
  int errors = 0;

  lfsr_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .cfg_shifts(cfg_shifts), .lfsr_state(lfsr_state), .lfsr_load(lfsr_load),
    .lfsr_seed(lfsr_seed), .lfsr_shift(lfsr_shift), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .shifts_done(shifts_done), .seed_fixed(seed_fixed)
  );

  always #5 clk = ~clk;

  // x^4 + x^3 + 1 Fibonacci step
  function automatic logic [3:0] lfsr_step(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  function automatic logic [3:0] ref_result(input logic [3:0] s, input int n);
    logic [3:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

  // Behavioural LFSR core driven by the controller strobes
  logic [3:0] lfsr_q = 4'd0;
  always @(posedge clk) begin
    if (lfsr_load) lfsr_q <= lfsr_seed;
    else if (lfsr_shift) lfsr_q <= lfsr_step(lfsr_q);
  end
  assign lfsr_state = lfsr_q;

  function automatic logic [16:0] all_outs();
    return {lfsr_load, lfsr_shift, busy, out_valid, out_data, lfsr_seed,
            shifts_done, seed_fixed};
  endfunction

  // Full run from IDLE; called just after a negedge, returns in IDLE.
  task automatic do_run(input logic [3:0] s, input logic [3:0] c,
                        input int bp, input string tag);
    int tgt;
    logic [3:0] exp_seed, exp_data, got, want;
    logic exp_fixed;
    tgt       = (c == 4'd0) ? 8 : int'(c);
    exp_fixed = FIX && (s == 4'd0);
    exp_seed  = exp_fixed ? 4'b1001 : s;
    exp_data  = ref_result(exp_seed, tgt);
    start = 1'b1; seed = s; cfg_shifts = c; out_ready = 1'b0; abort = 1'b0;
    for (int cyc = 1; cyc <= tgt + 2; cyc++) begin
      @(negedge clk);
      start = 1'b0; seed = 4'($urandom_range(15, 0));
      got  = {lfsr_load, lfsr_shift, out_valid, busy};
      want = {(cyc == 1), (cyc >= 2 && cyc <= tgt + 1), 1'b0, 1'b1};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s ctrl cyc=%0d got load/shift/valid/busy=%b want=%b", tag, cyc, got, want);
      end
      if (cyc == 1) begin
        checks++;
        if ({lfsr_seed, seed_fixed} !== {exp_seed, exp_fixed}) begin
          errors++;
          $display("FAIL %s seed got=%b fixed=%b want=%b fixed=%b", tag, lfsr_seed, seed_fixed, exp_seed, exp_fixed);
        end
      end
      if (cyc >= 2 && cyc <= tgt + 1) begin
        checks++;
        if (shifts_done !== 4'(cyc - 1)) begin
          errors++;
          $display("FAIL %s count cyc=%0d got=%0d want=%0d", tag, cyc, shifts_done, cyc - 1);
        end
      end
    end
    for (int k = 0; k <= bp; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, busy, out_data, shifts_done} !== {1'b1, 1'b1, exp_data, 4'(tgt)}) begin
        errors++;
        $display("FAIL %s done k=%0d got valid=%b busy=%b data=%b cnt=%0d want 1 1 %b %0d",
                 tag, k, out_valid, busy, out_data, shifts_done, exp_data, tgt);
      end
      if (k == bp) out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, busy, lfsr_load, lfsr_shift, out_data, shifts_done} !==
        {4'b0000, exp_data, 4'(tgt)}) begin
      errors++;
      $display("FAIL %s idle got valid=%b busy=%b data=%b cnt=%0d want 0 0 %b %0d",
               tag, out_valid, busy, out_data, shifts_done, exp_data, tgt);
    end
    $display("run %s seed=%b cfg=%0d bp=%0d result=%b", tag, s, c, bp, out_data);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = 4'd0;
    cfg_shifts = 4'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0", all_outs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs() !== 17'd0) begin
      errors++;
      $display("FAIL reset_idle got=%b want=0", all_outs());
    end
    $display("reset done");
  endtask

  task automatic test_default_length();
    do_run(4'b1001, 4'd0, 0, "default_len");
  endtask

  task automatic test_backpressure();
    do_run(4'($urandom_range(15, 1)), 4'd3, 5, "backpressure");
  endtask

  task automatic test_abort();
    logic [3:0] prev;
    prev = out_data;
    start = 1'b1; seed = 4'($urandom_range(15, 1)); cfg_shifts = 4'd0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if ({lfsr_shift, shifts_done} !== {1'b1, 4'd4}) begin
      errors++;
      $display("FAIL abort_pre got shift=%b cnt=%0d want 1 4", lfsr_shift, shifts_done);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({lfsr_load, lfsr_shift, out_valid, busy, shifts_done, out_data} !==
        {4'b0000, 4'd4, prev}) begin
      errors++;
      $display("FAIL abort_post got l/s/v/b=%b%b%b%b cnt=%0d data=%b want 0000 4 %b",
               lfsr_load, lfsr_shift, out_valid, busy, shifts_done, out_data, prev);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, busy, lfsr_shift} !== 3'b000) begin
        errors++;
        $display("FAIL abort_quiet k=%0d got valid/busy/shift=%b%b%b want 000", k, out_valid, busy, lfsr_shift);
      end
    end
    $display("abort done cnt=%0d", shifts_done);
  endtask

  task automatic test_ignored_start();
    logic [3:0] s0;
    s0 = 4'($urandom_range(15, 1));
    start = 1'b1; seed = s0; cfg_shifts = 4'd3;
    @(negedge clk); start = 1'b0;                       // LOAD
    @(negedge clk);                                     // RUN 1
    @(negedge clk); start = 1'b1; seed = ~s0; cfg_shifts = 4'd5; // RUN 2
    @(negedge clk); start = 1'b0;                       // RUN 3
    checks++;
    if ({lfsr_load, lfsr_shift, lfsr_seed, shifts_done} !== {1'b0, 1'b1, s0, 4'd3}) begin
      errors++;
      $display("FAIL ign_run got load=%b shift=%b seed=%b cnt=%0d want 0 1 %b 3",
               lfsr_load, lfsr_shift, lfsr_seed, shifts_done, s0);
    end
    @(negedge clk);                                     // CAPTURE
    @(negedge clk);                                     // DONE
    checks++;
    if ({out_valid, out_data} !== {1'b1, ref_result(s0, 3)}) begin
      errors++;
      $display("FAIL ign_done got valid=%b data=%b want 1 %b", out_valid, out_data, ref_result(s0, 3));
    end
    out_ready = 1'b1; start = 1'b1; seed = ~s0;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({busy, lfsr_load, out_valid} !== 3'b000) begin
        errors++;
        $display("FAIL ign_after k=%0d got busy/load/valid=%b%b%b want 000", k, busy, lfsr_load, out_valid);
      end
      @(negedge clk);
    end
    $display("ignored_start done seed=%b", s0);
  endtask

  task automatic test_mid_reset();
    start = 1'b1; seed = 4'($urandom_range(15, 1)); cfg_shifts = 4'd0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if ({lfsr_shift, shifts_done} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL mreset_pre got shift=%b cnt=%0d want 1 2", lfsr_shift, shifts_done);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (all_outs() !== 17'd0) begin
      errors++;
      $display("FAIL mreset_outputs got=%b want=0", all_outs());
    end
    $display("mid_reset done");
    do_run(4'($urandom_range(15, 1)), 4'($urandom_range(15, 0)), 1, "after_reset");
  endtask

  task automatic test_zero_seed();
    do_run(4'd0, 4'd2, 0, "zero_seed");
    do_run(4'($urandom_range(15, 1)), 4'd2, 0, "nonzero_after_zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_run(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
             int'($urandom_range(3, 0)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_default_length();
    test_backpressure();
    test_abort();
    test_ignored_start();
    test_mid_reset();
    test_zero_seed();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
